// File: rtl/rvcpu_mem_pkg.sv
// Shared types and constants for the memory-port arbiter.
package rvcpu_mem_pkg;

  localparam int unsigned RD_CTRL_W = 3;
  localparam int unsigned WR_CTRL_W = 2;

  // Load type used for instruction fetch: unsigned word
  localparam logic [RD_CTRL_W-1:0] FETCH_RD_CTRL = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter that flags a hung memory access. Cleared when a transaction is
// granted, counts while one is outstanding. TIMEOUT_CYCLES = 0 disables it.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] cnt;

  // Count busy cycles; restart on each new grant
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && en && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the data port.
// Data has fixed priority; a streak limit guarantees fetch eventually wins.
module mem_port_arbiter
  import rvcpu_mem_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // fetch port
  input  logic                 if_req,
  input  logic [63:0]          if_addr,
  output logic [31:0]          if_rdata,
  output logic                 if_valid,
  output logic                 if_stall,
  // data port
  input  logic                 dm_req,
  input  logic [63:0]          dm_addr,
  input  logic [63:0]          dm_wdata,
  input  logic [RD_CTRL_W-1:0] dm_rd_ctrl,
  input  logic [WR_CTRL_W-1:0] dm_wr_ctrl,
  output logic [63:0]          dm_rdata,
  output logic                 dm_valid,
  output logic                 dm_stall,
  // memory side
  output logic                 mem_req,
  output logic [63:0]          mem_addr,
  output logic [63:0]          mem_wdata,
  output logic [RD_CTRL_W-1:0] mem_rd_ctrl,
  output logic [WR_CTRL_W-1:0] mem_wr_ctrl,
  output logic                 mem_is_fetch,
  input  logic                 mem_ack,
  input  logic [63:0]          mem_rdata,
  output logic                 err_timeout
);

  localparam int unsigned STREAK_W = $clog2(DATA_STREAK_MAX + 1);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic                busy;
  logic                fetch_blocked;
  logic                grant_data;
  logic                grant_fetch;
  logic                timeout;

  assign busy          = (state != IDLE);
  // Fetch has waited out the full data streak, so it takes the next grant
  assign fetch_blocked = if_req && (streak == STREAK_W'(DATA_STREAK_MAX));
  assign grant_data    = (state == IDLE) && dm_req && !fetch_blocked;
  assign grant_fetch   = (state == IDLE) && !grant_data && if_req;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_data || grant_fetch),
    .en      (busy),
    .timeout (timeout)
  );

  // Arbitration FSM with registered memory-side and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      streak       <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd_ctrl  <= '0;
      mem_wr_ctrl  <= '0;
      mem_is_fetch <= 1'b0;
      if_valid     <= 1'b0;
      if_rdata     <= '0;
      dm_valid     <= 1'b0;
      dm_rdata     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            state        <= DATA;
            mem_req      <= 1'b1;
            mem_addr     <= dm_addr;
            mem_wdata    <= dm_wdata;
            mem_rd_ctrl  <= dm_rd_ctrl;
            mem_wr_ctrl  <= dm_wr_ctrl;
            mem_is_fetch <= 1'b0;
            if (if_req) begin
              if (streak != STREAK_W'(DATA_STREAK_MAX)) begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end else if (grant_fetch) begin
            state        <= FETCH;
            mem_req      <= 1'b1;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            mem_rd_ctrl  <= FETCH_RD_CTRL;
            mem_wr_ctrl  <= '0;
            mem_is_fetch <= 1'b1;
            streak       <= '0;
          end
        end
        FETCH, DATA: begin
          // An ack in the timeout cycle still completes normally
          if (mem_ack || timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata[31:0] : 32'h0;
            end else begin
              dm_valid <= 1'b1;
              dm_rdata <= mem_ack ? mem_rdata : 64'h0;
            end
            if (!mem_ack) begin
              err_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level reference model (owner / age / streak bookkeeping).
module tb_mem_port_arbiter;
  import rvcpu_mem_pkg::*;

  localparam int STREAK = 4;
  localparam int TO     = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_rd_ctrl;
  logic [1:0]  dm_wr_ctrl;
  logic        dm_valid, dm_stall;
  logic        mem_req;
  logic [63:0] mem_addr, mem_wdata;
  logic [2:0]  mem_rd_ctrl;
  logic [1:0]  mem_wr_ctrl;
  logic        mem_is_fetch;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        err_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_STREAK_MAX (STREAK),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .dm_req       (dm_req),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rd_ctrl   (dm_rd_ctrl),
    .dm_wr_ctrl   (dm_wr_ctrl),
    .dm_rdata     (dm_rdata),
    .dm_valid     (dm_valid),
    .dm_stall     (dm_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd_ctrl  (mem_rd_ctrl),
    .mem_wr_ctrl  (mem_wr_ctrl),
    .mem_is_fetch (mem_is_fetch),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .err_timeout  (err_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns memory, how long it has been waiting, streak length
  int          m_owner;  // 0 none, 1 fetch, 2 data
  int          m_age;
  int          m_streak;
  bit          m_mem_req, m_if_valid, m_dm_valid, m_err, m_is_fetch;
  logic [63:0] m_addr, m_wdata, m_dm_rdata;
  logic [31:0] m_if_rdata;
  logic [2:0]  m_rd;
  logic [1:0]  m_wr;

  int ack_delay = 0;
  bit rand_mode = 0;

  task automatic model_step();
    m_if_valid = 0;
    m_dm_valid = 0;
    if (rst) begin
      m_owner = 0; m_age = 0; m_streak = 0; m_mem_req = 0; m_err = 0; m_is_fetch = 0;
      m_addr = '0; m_wdata = '0; m_rd = '0; m_wr = '0; m_if_rdata = '0; m_dm_rdata = '0;
    end else if (m_owner == 0) begin
      if (dm_req && !(if_req && m_streak == STREAK)) begin
        m_owner = 2; m_is_fetch = 0; m_mem_req = 1; m_age = 0;
        m_addr = dm_addr; m_wdata = dm_wdata; m_rd = dm_rd_ctrl; m_wr = dm_wr_ctrl;
        m_streak = if_req ? ((m_streak < STREAK) ? m_streak + 1 : STREAK) : 0;
      end else if (if_req) begin
        m_owner = 1; m_is_fetch = 1; m_mem_req = 1; m_age = 0;
        m_addr = if_addr; m_rd = FETCH_RD_CTRL; m_wr = 2'd0; m_streak = 0;
      end
    end else begin
      if (mem_ack || (TO != 0 && m_age == TO - 1)) begin
        if (m_owner == 1) begin
          m_if_valid = 1;
          m_if_rdata = mem_ack ? mem_rdata[31:0] : 32'h0;
        end else begin
          m_dm_valid = 1;
          m_dm_rdata = mem_ack ? mem_rdata : 64'h0;
        end
        if (!mem_ack) m_err = 1;
        m_owner = 0;
        m_mem_req = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic compare_all();
    check("mem_req", mem_req, m_mem_req);
    check("if_valid", if_valid, m_if_valid);
    check("dm_valid", dm_valid, m_dm_valid);
    check("err_timeout", err_timeout, m_err);
    if (m_mem_req) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_rd_ctrl", mem_rd_ctrl, m_rd);
      check("mem_wr_ctrl", mem_wr_ctrl, m_wr);
      check("mem_is_fetch", mem_is_fetch, m_is_fetch);
      if (!m_is_fetch) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_if_valid) check("if_rdata", if_rdata, m_if_rdata);
    if (m_dm_valid) check("dm_rdata", dm_rdata, m_dm_rdata);
  endtask

  // One clock: drive memory response, check stalls, advance model, compare after edge
  task automatic step();
    if (rand_mode) mem_rdata = {$urandom, $urandom};
    if (m_mem_req) begin
      if (rand_mode && m_age == 0) ack_delay = $urandom_range(0, 9);
      mem_ack = (m_age == ack_delay);
    end else begin
      mem_ack = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    #1;
    if (!rst) begin
      check("if_stall", if_stall, if_req & ~m_if_valid);
      check("dm_stall", dm_stall, dm_req & ~m_dm_valid);
    end
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_load(input logic [63:0] addr);
    dm_req = 1'b1; dm_addr = addr; dm_wdata = 64'h0; dm_rd_ctrl = 3'd3; dm_wr_ctrl = 2'd0;
  endtask

  int n;
  int n_req;
  bit prev_req;
  logic [1:0] wr_seen;
  bit grants[$];
  bit exp_seq [6];

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_addr = '0; dm_wdata = '0;
    dm_rd_ctrl = '0; dm_wr_ctrl = '0; mem_ack = 0; mem_rdata = '0;

    // Reset state
    do_reset();
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_rd_ctrl", mem_rd_ctrl, 3'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 64'h0);

    // Solo fetch: valid two cycles after the request
    if_req = 1; if_addr = 64'h100; mem_rdata = 64'hDEADBEEF_00000013; ack_delay = 0;
    n = 0; wr_seen = 2'b11;
    while (!m_if_valid && n < 40) begin
      step(); n++;
      if (mem_req) wr_seen = mem_wr_ctrl;
    end
    check("fetch_latency", n, 2);
    check("fetch_rdata", if_rdata, 32'h00000013);
    check("fetch_wr_ctrl", wr_seen, 2'd0);
    if_req = 0;

    // Collision: data first, then fetch
    if_req = 1; if_addr = 64'h3000;
    dm_req = 1; dm_addr = 64'h2000; dm_wdata = 64'h55; dm_rd_ctrl = 3'd0; dm_wr_ctrl = 2'd3;
    ack_delay = 1;
    step();
    check("coll_is_fetch", mem_is_fetch, 1'b0);
    check("coll_addr", mem_addr, 64'h2000);
    check("coll_wdata", mem_wdata, 64'h55);
    check("coll_wr_ctrl", mem_wr_ctrl, 2'd3);
    n = 0;
    while (!m_dm_valid && n < 40) begin
      check("coll_if_stall", if_stall, 1'b1);
      step(); n++;
    end
    dm_req = 0;
    step();
    check("coll_fetch_grant", mem_is_fetch, 1'b1);
    n = 0;
    while (!m_if_valid && n < 40) begin
      check("coll_if_stall", if_stall, 1'b1);
      step(); n++;
    end
    check("coll_fetch_done", if_valid, 1'b1);
    if_req = 0;

    // Starvation guard: four data grants, one fetch, then data again
    do_reset();
    set_load(64'h80); if_req = 1; if_addr = 64'h400; ack_delay = 0;
    prev_req = 0;
    repeat (14) begin
      step();
      if (mem_req && !prev_req) grants.push_back(mem_is_fetch);
      prev_req = mem_req;
    end
    exp_seq = '{0, 0, 0, 0, 1, 0};
    check("starve_count", grants.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) check("starve_grant", grants[i], exp_seq[i]);
    end
    if_req = 0; dm_req = 0;

    // Watchdog abort of a never-acked load
    do_reset();
    set_load(64'h40); ack_delay = -1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    n = 0; n_req = 0;
    while (!m_dm_valid && n < 40) begin
      step(); n++;
      if (mem_req) n_req++;
    end
    check("to_req_cycles", n_req, TO);
    check("to_dm_valid", dm_valid, 1'b1);
    check("to_dm_rdata", dm_rdata, 64'h0);
    check("to_err", err_timeout, 1'b1);
    dm_req = 0;
    repeat (3) step();
    check("to_err_sticky", err_timeout, 1'b1);

    // Ack in the timeout cycle completes normally
    do_reset();
    set_load(64'h48); ack_delay = TO - 1; mem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    n = 0;
    while (!m_dm_valid && n < 40) begin
      step(); n++;
    end
    check("tie_dm_valid", dm_valid, 1'b1);
    check("tie_rdata", dm_rdata, 64'hCAFE_F00D_0BAD_BEEF);
    check("tie_err", err_timeout, 1'b0);
    dm_req = 0;

    // Reset in the middle of a data access
    do_reset();
    set_load(64'h50); ack_delay = 5;
    n = 0;
    while (!(m_mem_req && m_age == 2) && n < 40) begin
      step(); n++;
    end
    rst = 1;
    step();
    check("mrst_mem_req", mem_req, 1'b0);
    check("mrst_dm_valid", dm_valid, 1'b0);
    check("mrst_err", err_timeout, 1'b0);
    rst = 0; if_req = 1; if_addr = 64'h500;
    step();
    check("mrst_regrant_data", mem_is_fetch, 1'b0);
    n = 0;
    while (!m_dm_valid && n < 40) begin
      step(); n++;
    end
    dm_req = 0;
    n = 0;
    while (!m_if_valid && n < 40) begin
      step(); n++;
    end
    if_req = 0;

    // Randomized traffic with occasional resets, spurious acks and timeouts
    rand_mode = 1;
    repeat (3000) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 599) == 0) rst = 1;
      if (if_req && (m_if_valid || $urandom_range(0, 49) == 0)) if_req = 0;
      if (dm_req && (m_dm_valid || $urandom_range(0, 49) == 0)) dm_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {$urandom, $urandom};
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
        dm_rd_ctrl = 3'($urandom_range(0, 7)); dm_wr_ctrl = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

endmodule
